// File: rtl/bitstream_reader_if.sv
// Signal bundle between the word FIFO / CAVLC decoder and bitstream_reader.
// Optional BitCount member is present when BITSTREAM_READER_BITCOUNT_EN is defined.
interface bitstream_reader_if #(
    parameter int WORD_W = 16,
    parameter int BUF_W  = 32,
    parameter int PEEK_W = 16
);
    localparam int LEN_W = $clog2(PEEK_W) + 1;
    localparam int CNT_W = $clog2(BUF_W) + 1;

    logic [WORD_W-1:0] FifoData;
    logic              FifoEmpty;
    logic              FifoRead;
    logic              ConsumeValid;
    logic [LEN_W-1:0]  ConsumeLen;
    logic              Flush;
    logic [PEEK_W-1:0] Peek;
    logic [CNT_W-1:0]  BitsAvail;
    logic              PeekValid;
    logic              Error;
    logic              DbgFetchState;
`ifdef BITSTREAM_READER_BITCOUNT_EN
    logic [31:0]       BitCount;

    modport master (
        output FifoData, FifoEmpty, ConsumeValid, ConsumeLen, Flush,
        input  FifoRead, Peek, BitsAvail, PeekValid, Error, DbgFetchState, BitCount
    );
    modport slave (
        input  FifoData, FifoEmpty, ConsumeValid, ConsumeLen, Flush,
        output FifoRead, Peek, BitsAvail, PeekValid, Error, DbgFetchState, BitCount
    );
`else
    modport master (
        output FifoData, FifoEmpty, ConsumeValid, ConsumeLen, Flush,
        input  FifoRead, Peek, BitsAvail, PeekValid, Error, DbgFetchState
    );
    modport slave (
        input  FifoData, FifoEmpty, ConsumeValid, ConsumeLen, Flush,
        output FifoRead, Peek, BitsAvail, PeekValid, Error, DbgFetchState
    );
`endif
endinterface

// File: rtl/bitstream_reader.sv
// MSB-first bit window fed from a 16-bit word FIFO, with variable-length consume.
// Define BITSTREAM_READER_BITCOUNT_EN to add the BitCount consumed-bits counter.
module bitstream_reader #(
    parameter int WORD_W = 16,
    parameter int BUF_W  = 32,
    parameter int PEEK_W = 16
) (
    input  logic              Clk,
    input  logic              nReset,
    bitstream_reader_if.slave bus
);
    localparam int LEN_W = $clog2(PEEK_W) + 1;
    localparam int CNT_W = $clog2(BUF_W) + 1;
    localparam logic [CNT_W-1:0] PeekLen     = CNT_W'(PEEK_W);
    localparam logic [CNT_W-1:0] RefillLimit = CNT_W'(BUF_W - WORD_W);
    localparam logic [CNT_W-1:0] WordLen     = CNT_W'(WORD_W);

    // Handshakes: FifoRead is a one-cycle strobe only when FifoEmpty=0 and no read
    // is outstanding; the word is taken from FifoData exactly one cycle later.
    // ConsumeValid/ConsumeLen need no ready: a consume is accepted the same cycle
    // if ConsumeLen <= min(BitsAvail, PEEK_W), otherwise it is dropped and flagged.
    typedef enum logic {FetchIdle, FetchWait} fetchStateT;

    fetchStateT       stateQ, stateD;
    logic [BUF_W-1:0] bufQ, bufD, shifted;
    logic [CNT_W-1:0] availQ, availD, availAfter, lenExt;
    logic             errorQ, errorD;
    logic             consumeLegal, consumeIllegal, fifoRead;

    assign lenExt = {{(CNT_W-LEN_W){1'b0}}, bus.ConsumeLen};

    always_comb begin
        consumeLegal   = 1'b0;
        consumeIllegal = 1'b0;
        availAfter     = availQ;
        shifted        = bufQ;
        fifoRead       = 1'b0;
        stateD         = FetchIdle;
        bufD           = bufQ;
        availD         = availQ;
        errorD         = errorQ;

        if (bus.ConsumeValid && !bus.Flush) begin
            if ((lenExt <= PeekLen) && (lenExt <= availQ)) consumeLegal   = 1'b1;
            else                                           consumeIllegal = 1'b1;
        end

        if (consumeLegal) begin
            availAfter = availQ - lenExt;
            shifted    = bufQ << bus.ConsumeLen;
        end

        // Refill decision looks at the post-consume level so a word always fits.
        fifoRead = nReset && !bus.FifoEmpty && (stateQ == FetchIdle) && !bus.Flush &&
                   (availAfter <= RefillLimit);
        if (fifoRead) stateD = FetchWait;

        if (bus.Flush) begin
            bufD   = '0;
            availD = '0;
        end else begin
            bufD   = shifted;
            availD = availAfter;
            if (stateQ == FetchWait) begin
                bufD   = shifted | ({bus.FifoData, {(BUF_W-WORD_W){1'b0}}} >> availAfter);
                availD = availAfter + WordLen;
            end
        end

        if (consumeIllegal) errorD = 1'b1;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            stateQ <= FetchIdle;
            bufQ   <= '0;
            availQ <= '0;
            errorQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            bufQ   <= bufD;
            availQ <= availD;
            errorQ <= errorD;
        end
    end

`ifdef BITSTREAM_READER_BITCOUNT_EN
    logic [31:0] bitCountQ;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            bitCountQ <= '0;
        end else if (bus.Flush) begin
            bitCountQ <= '0;
        end else if (consumeLegal) begin
            bitCountQ <= bitCountQ + 32'(bus.ConsumeLen);
        end
    end

    assign bus.BitCount = bitCountQ;
`endif

    assign bus.FifoRead      = fifoRead;
    assign bus.Peek          = bufQ[BUF_W-1 -: PEEK_W];
    assign bus.BitsAvail     = availQ;
    assign bus.PeekValid     = (availQ >= PeekLen);
    assign bus.Error         = errorQ;
    assign bus.DbgFetchState = (stateQ == FetchWait);
endmodule

// File: tb/tb_bitstream_reader.sv
// Bench for bitstream_reader: FIFO model, bit-queue stream model and expected-output scoreboard.
// Build with BITSTREAM_READER_BITCOUNT_EN defined to also track BitCount.
`timescale 1ns/1ps
module tb_bitstream_reader;
`ifdef BITSTREAM_READER_BITCOUNT_EN
    localparam int EXP_W = 56;
`else
    localparam int EXP_W = 24;
`endif

    logic Clk    = 1'b0;
    logic nReset = 1'b0;

    bitstream_reader_if bus();
    bitstream_reader dut (.Clk(Clk), .nReset(nReset), .bus(bus));

    always #5 Clk = ~Clk;

    logic [EXP_W-1:0] expQ[$];
    logic [15:0]      fifoQ[$];
    bit               modelBits[$];
    logic             modelPending;
    logic             modelError;
    logic [31:0]      modelCount;
    logic [15:0]      fifoWord;
    int nChecks    = 0;
    int nFails     = 0;
    int readPulses = 0;
    int underflows = 0;

    function automatic logic [EXP_W-1:0] model_expect();
        logic [15:0] p;
        logic [5:0]  a;
        p = '0;
        for (int i = 0; i < 16; i++) if (i < modelBits.size()) p[15-i] = modelBits[i];
        a = 6'(modelBits.size());
`ifdef BITSTREAM_READER_BITCOUNT_EN
        return {modelCount, p, a, (a >= 6'd16), modelError};
`else
        return {p, a, (a >= 6'd16), modelError};
`endif
    endfunction

    task automatic model_clear();
        modelBits.delete();
        expQ.delete();
        modelPending = 1'b0;
        modelError   = 1'b0;
        modelCount   = '0;
    endtask

    task automatic fifo_push(input logic [15:0] w);
        fifoQ.push_back(w);
        bus.FifoEmpty = 1'b0;
    endtask

    // One clock: drive inputs, check FifoRead, advance models, serve FIFO, score outputs.
    task automatic drive_cycle(input logic cv, input logic [4:0] len, input logic fl);
        logic legal, expRead, rd;
        int after;
        bit dropped;
        logic [EXP_W-1:0] expv, act;
        bus.ConsumeValid = cv;
        bus.ConsumeLen   = len;
        bus.Flush        = fl;
        legal   = cv && !fl && (int'(len) <= 16) && (int'(len) <= modelBits.size());
        after   = legal ? modelBits.size() - int'(len) : modelBits.size();
        expRead = !bus.FifoEmpty && !modelPending && !fl && (after <= 16);
        @(negedge Clk);
        rd = bus.FifoRead;
        nChecks++;
        if (rd !== expRead) begin
            nFails++;
            $display("FAIL fifo_read @%0t: got %b want %b", $time, rd, expRead);
        end
        if (rd === 1'b1) readPulses++;
        if (rd === 1'b1 && bus.FifoEmpty) underflows++;
        if (fl) begin
            modelBits.delete();
            modelCount = '0;
        end else begin
            if (legal) begin
                for (int i = 0; i < int'(len); i++) dropped = modelBits.pop_front();
                modelCount = modelCount + 32'(len);
            end else if (cv) begin
                modelError = 1'b1;
            end
            if (modelPending) for (int i = 15; i >= 0; i--) modelBits.push_back(fifoWord[i]);
        end
        modelPending = expRead;
        expQ.push_back(model_expect());
        @(posedge Clk);
        #1;
        if (rd === 1'b1 && fifoQ.size() > 0) begin
            fifoWord     = fifoQ.pop_front();
            bus.FifoData = fifoWord;
        end else begin
            bus.FifoData = 16'($urandom);
        end
        bus.FifoEmpty = (fifoQ.size() == 0);
`ifdef BITSTREAM_READER_BITCOUNT_EN
        act = {bus.BitCount, bus.Peek, bus.BitsAvail, bus.PeekValid, bus.Error};
`else
        act = {bus.Peek, bus.BitsAvail, bus.PeekValid, bus.Error};
`endif
        expv = expQ.pop_front();
        nChecks++;
        if (act !== expv) begin
            nFails++;
            $display("FAIL scoreboard @%0t: got %h want %h ([count,]peek,avail,pv,err)", $time, act, expv);
        end
    endtask

    task automatic apply_reset();
        nReset = 1'b0;
        bus.ConsumeValid = 1'b0;
        bus.ConsumeLen   = '0;
        bus.Flush        = 1'b0;
        @(negedge Clk);
        @(posedge Clk);
        #1;
        nReset = 1'b1;
        model_clear();
        bus.FifoEmpty = (fifoQ.size() == 0);
    endtask

    task automatic test_reset();
        bus.FifoData = '0;
        bus.FifoEmpty = 1'b1;
        bus.ConsumeValid = 1'b0;
        bus.ConsumeLen = '0;
        bus.Flush = 1'b0;
        fifoWord = '0;
        model_clear();
        repeat (2) @(posedge Clk);
        #1;
        nChecks++;
        if ({bus.Peek, bus.BitsAvail, bus.PeekValid, bus.Error, bus.FifoRead} !== 25'd0) begin
            nFails++;
            $display("FAIL reset_outputs: got peek=%h avail=%0d pv=%b err=%b rd=%b want all 0",
                     bus.Peek, bus.BitsAvail, bus.PeekValid, bus.Error, bus.FifoRead);
        end
`ifdef BITSTREAM_READER_BITCOUNT_EN
        nChecks++;
        if (bus.BitCount !== 32'd0) begin
            nFails++;
            $display("FAIL reset_bitcount: got %0d want 0", bus.BitCount);
        end
`endif
        nReset = 1'b1;
        drive_cycle(1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_first_word();
        fifo_push(16'hA5C3);
        drive_cycle(1'b0, 5'd0, 1'b0);
        nChecks++;
        if (bus.PeekValid !== 1'b0) begin
            nFails++;
            $display("FAIL first_word_early_valid: got %b want 0", bus.PeekValid);
        end
        drive_cycle(1'b0, 5'd0, 1'b0);
        nChecks++;
        if (bus.Peek !== 16'hA5C3 || bus.BitsAvail !== 6'd16 || bus.PeekValid !== 1'b1 || bus.Error !== 1'b0) begin
            nFails++;
            $display("FAIL first_word: got peek=%h avail=%0d pv=%b err=%b want a5c3 16 1 0",
                     bus.Peek, bus.BitsAvail, bus.PeekValid, bus.Error);
        end
        drive_cycle(1'b0, 5'd0, 1'b0);
        nChecks++;
        if (readPulses !== 1) begin
            nFails++;
            $display("FAIL first_word_reads: got %0d want 1", readPulses);
        end
    endtask

    task automatic test_consume_seq();
        fifo_push(16'h0F0F);
        drive_cycle(1'b1, 5'd4, 1'b0);
        nChecks++;
        if (bus.Peek !== 16'h5C30 || bus.BitsAvail !== 6'd12) begin
            nFails++;
            $display("FAIL consume_first: got peek=%h avail=%0d want 5c30 12", bus.Peek, bus.BitsAvail);
        end
        drive_cycle(1'b1, 5'd4, 1'b0);
        nChecks++;
        if (bus.Peek !== 16'hC30F || bus.BitsAvail !== 6'd24) begin
            nFails++;
            $display("FAIL consume_refill: got peek=%h avail=%0d want c30f 24", bus.Peek, bus.BitsAvail);
        end
        drive_cycle(1'b1, 5'd8, 1'b0);
        drive_cycle(1'b1, 5'd4, 1'b0);
        nChecks++;
        if (bus.Peek !== 16'hF0F0 || bus.BitsAvail !== 6'd12) begin
            nFails++;
            $display("FAIL consume_final: got peek=%h avail=%0d want f0f0 12", bus.Peek, bus.BitsAvail);
        end
    endtask

    task automatic test_arrival_consume16();
        drive_cycle(1'b1, 5'd12, 1'b0);
        fifo_push(16'h1234);
        fifo_push(16'hBEEF);
        drive_cycle(1'b0, 5'd0, 1'b0);
        drive_cycle(1'b0, 5'd0, 1'b0);
        drive_cycle(1'b0, 5'd0, 1'b0);
        drive_cycle(1'b1, 5'd16, 1'b0);
        nChecks++;
        if (bus.Peek !== 16'hBEEF || bus.BitsAvail !== 6'd16) begin
            nFails++;
            $display("FAIL arrival_consume16: got peek=%h avail=%0d want beef 16", bus.Peek, bus.BitsAvail);
        end
    endtask

    task automatic test_illegal_underrun();
        drive_cycle(1'b1, 5'd13, 1'b0);
        drive_cycle(1'b1, 5'd0, 1'b0);
        drive_cycle(1'b1, 5'd5, 1'b0);
        nChecks++;
        if (bus.Peek !== 16'hE000 || bus.BitsAvail !== 6'd3 || bus.Error !== 1'b1) begin
            nFails++;
            $display("FAIL illegal_underrun: got peek=%h avail=%0d err=%b want e000 3 1",
                     bus.Peek, bus.BitsAvail, bus.Error);
        end
        repeat (3) drive_cycle(1'b0, 5'd0, 1'b0);
        nChecks++;
        if (bus.Error !== 1'b1) begin
            nFails++;
            $display("FAIL error_sticky: got %b want 1", bus.Error);
        end
    endtask

    task automatic test_reset_mid_fetch();
        fifo_push(16'h7777);
        fifo_push(16'h8888);
        drive_cycle(1'b0, 5'd0, 1'b0);
        nReset = 1'b0;
        #1;
        nChecks++;
        if ({bus.Peek, bus.BitsAvail, bus.PeekValid, bus.Error, bus.FifoRead} !== 25'd0) begin
            nFails++;
            $display("FAIL reset_mid_fetch: got peek=%h avail=%0d pv=%b err=%b rd=%b want all 0",
                     bus.Peek, bus.BitsAvail, bus.PeekValid, bus.Error, bus.FifoRead);
        end
        apply_reset();
        drive_cycle(1'b0, 5'd0, 1'b0);
        drive_cycle(1'b0, 5'd0, 1'b0);
        nChecks++;
        if (bus.Peek !== 16'h8888 || bus.BitsAvail !== 6'd16) begin
            nFails++;
            $display("FAIL refetch_after_reset: got peek=%h avail=%0d want 8888 16", bus.Peek, bus.BitsAvail);
        end
    endtask

    task automatic test_illegal_len17();
        fifo_push(16'h1111);
        drive_cycle(1'b0, 5'd0, 1'b0);
        drive_cycle(1'b0, 5'd0, 1'b0);
        drive_cycle(1'b1, 5'd17, 1'b0);
        nChecks++;
        if (bus.BitsAvail !== 6'd32 || bus.Error !== 1'b1 || bus.Peek !== 16'h8888) begin
            nFails++;
            $display("FAIL illegal_len17: got peek=%h avail=%0d err=%b want 8888 32 1",
                     bus.Peek, bus.BitsAvail, bus.Error);
        end
    endtask

    task automatic test_bitcount();
        drive_cycle(1'b1, 5'd7, 1'b0);
`ifdef BITSTREAM_READER_BITCOUNT_EN
        nChecks++;
        if (bus.BitCount !== 32'd7) begin
            nFails++;
            $display("FAIL bitcount_7: got %0d want 7", bus.BitCount);
        end
`endif
        drive_cycle(1'b1, 5'd9, 1'b0);
        drive_cycle(1'b1, 5'd20, 1'b0);
        nChecks++;
        if (bus.BitsAvail !== 6'd16) begin
            nFails++;
            $display("FAIL bitcount_avail: got %0d want 16", bus.BitsAvail);
        end
`ifdef BITSTREAM_READER_BITCOUNT_EN
        nChecks++;
        if (bus.BitCount !== 32'd16) begin
            nFails++;
            $display("FAIL bitcount_16: got %0d want 16", bus.BitCount);
        end
`endif
    endtask

    task automatic test_flush();
        apply_reset();
        fifo_push(16'hCAFE);
        fifo_push(16'h5A5A);
        fifo_push(16'h0001);
        drive_cycle(1'b0, 5'd0, 1'b0);
        drive_cycle(1'b0, 5'd0, 1'b0);
        drive_cycle(1'b1, 5'd4, 1'b0);
        // Flush lands while 5A5A is in flight; the illegal length must not flag.
        drive_cycle(1'b1, 5'd20, 1'b1);
        nChecks++;
        if (bus.BitsAvail !== 6'd0 || bus.Peek !== 16'h0000 || bus.Error !== 1'b0) begin
            nFails++;
            $display("FAIL flush_clear: got peek=%h avail=%0d err=%b want 0000 0 0",
                     bus.Peek, bus.BitsAvail, bus.Error);
        end
`ifdef BITSTREAM_READER_BITCOUNT_EN
        nChecks++;
        if (bus.BitCount !== 32'd0) begin
            nFails++;
            $display("FAIL flush_bitcount: got %0d want 0", bus.BitCount);
        end
`endif
        drive_cycle(1'b0, 5'd0, 1'b0);
        drive_cycle(1'b0, 5'd0, 1'b0);
        nChecks++;
        if (bus.Peek !== 16'h0001 || bus.BitsAvail !== 6'd16) begin
            nFails++;
            $display("FAIL flush_refetch: got peek=%h avail=%0d want 0001 16", bus.Peek, bus.BitsAvail);
        end
    endtask

    task automatic test_random();
        logic cv, fl;
        logic [4:0] len;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            if (fifoQ.size() < 3 && $urandom_range(0, 2) != 0) fifo_push(16'($urandom));
            cv  = ($urandom_range(0, 3) != 0);
            len = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 16));
            fl  = ($urandom_range(0, 31) == 0);
            drive_cycle(cv, len, fl);
        end
    endtask

    task automatic test_no_underflow();
        nChecks++;
        if (underflows !== 0) begin
            nFails++;
            $display("FAIL no_underflow: got %0d reads while empty want 0", underflows);
        end
        nChecks++;
        if (expQ.size() !== 0) begin
            nFails++;
            $display("FAIL scoreboard_drain: got %0d left want 0", expQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_consume_seq();
        test_arrival_consume16();
        test_illegal_underrun();
        test_reset_mid_fetch();
        test_illegal_len17();
        test_bitcount();
        test_flush();
        test_random();
        test_no_underflow();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
